// File: rtl/dmem_responder.sv
// dmem_responder: word-addressed data memory behind valid/ready request/response
// channels with programmable wait states. Define DMEM_RESPONDER_BOUNDS_ERR_EN for rsp_err.
module dmem_responder #(
  parameter int ADDR_W      = 12,
  parameter int DEPTH       = 4096,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_store,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [3:0]        req_wstrb,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

`ifdef DMEM_RESPONDER_BOUNDS_ERR_EN
  localparam logic ERR_EN = 1'b1;
`else
  localparam logic ERR_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    COMMIT,
    RESP
  } state_e;

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              store_q, store_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [3:0]        wstrb_q, wstrb_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [31:0]       rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;

  logic [31:0]      mem [DEPTH];
  logic             in_range;
  logic [IDX_W-1:0] idx;
  logic             mem_we;

  assign in_range  = (32'(addr_q) < 32'(DEPTH));
  assign idx       = addr_q[IDX_W-1:0];
  assign req_ready = (state_q == IDLE) && !rst;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    store_d     = store_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    mem_we      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req_valid && req_ready) begin
          store_d = req_store;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          wstrb_d = req_wstrb;
          if (WAIT_CYCLES > 0) begin
            state_d = WAIT;
            cnt_d   = 4'(WAIT_CYCLES - 1);
          end else begin
            state_d = COMMIT;
          end
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) state_d = COMMIT;
        else cnt_d = cnt_q - 4'd1;
      end
      COMMIT: begin
        mem_we      = store_q && in_range;
        rsp_rdata_d = (!store_q && in_range) ? mem[idx] : 32'd0;
        rsp_err_d   = ERR_EN && !in_range;
        state_d     = RESP;
      end
      RESP: begin
        // valid is registered, so it rises one cycle after entering RESP
        if (!rsp_valid_q) begin
          rsp_valid_d = 1'b1;
        end else if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          rsp_rdata_d = 32'd0;
          rsp_err_d   = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      store_q     <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= 32'd0;
      wstrb_q     <= 4'd0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'd0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      store_q     <= store_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // storage is deliberately not reset
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (wstrb_q[i]) mem[idx][8*i +: 8] <= wdata_q[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: scoreboard bench; dut 0 has two wait states and 1024 words,
// dut 1 has zero wait states and the default depth.
module tb_dmem_responder;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          acc;
  } exp_t;

  localparam int W0 = 2;
  localparam int W1 = 0;

`ifdef DMEM_RESPONDER_BOUNDS_ERR_EN
  localparam logic EE = 1'b1;
`else
  localparam logic EE = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid [2];
  logic        req_ready [2];
  logic        req_store [2];
  logic [11:0] req_addr  [2];
  logic [31:0] req_wdata [2];
  logic [3:0]  req_wstrb [2];
  logic        rsp_valid [2];
  logic        rsp_ready [2];
  logic [31:0] rsp_rdata [2];
  logic        rsp_err   [2];

  exp_t q0[$];
  exp_t q1[$];
  exp_t cur [2];
  bit   seen [2];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   last_acc [2];
  int   hs;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dmem_responder #(.ADDR_W(12), .DEPTH(1024), .WAIT_CYCLES(W0)) u_dut0 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_store(req_store[0]), .req_addr(req_addr[0]),
    .req_wdata(req_wdata[0]), .req_wstrb(req_wstrb[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
    .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0])
  );

  dmem_responder #(.ADDR_W(12), .DEPTH(4096), .WAIT_CYCLES(W1)) u_dut1 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_store(req_store[1]), .req_addr(req_addr[1]),
    .req_wdata(req_wdata[1]), .req_wstrb(req_wstrb[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
    .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1])
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  task automatic fail_now(input string nm);
    checks++;
    failures++;
    $display("FAIL %s", nm);
  endtask

  task automatic mon(input int d);
    exp_t e;
    int   w;
    w = (d == 0) ? W0 : W1;
    if (rst) begin
      seen[d] = 1'b0;
      return;
    end
    if (rsp_valid[d] && !seen[d]) begin
      seen[d] = 1'b1;
      if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
        fail_now($sformatf("unexpected_rsp dut%0d", d));
      end else begin
        if (d == 0) e = q0.pop_front();
        else e = q1.pop_front();
        cur[d] = e;
        chk($sformatf("rdata dut%0d", d), rsp_rdata[d], e.rdata);
        chk($sformatf("err dut%0d", d), 32'(rsp_err[d]), 32'(e.err));
        chk($sformatf("latency dut%0d", d), cyc, e.acc + w + 2);
      end
    end else if (rsp_valid[d] && seen[d]) begin
      chk($sformatf("rdata_stable dut%0d", d), rsp_rdata[d], cur[d].rdata);
    end
    if (!rsp_valid[d] || rsp_ready[d]) seen[d] = 1'b0;
  endtask

  always @(negedge clk) begin
    #2;
    mon(0);
    mon(1);
  end

  // entered and left on a falling edge
  task automatic drive(input int d, input logic st, input logic [11:0] a,
                       input logic [31:0] wd, input logic [3:0] ws,
                       input logic [31:0] er, input logic ee);
    exp_t e;
    int   n;
    req_valid[d] = 1'b1;
    req_store[d] = st;
    req_addr[d]  = a;
    req_wdata[d] = wd;
    req_wstrb[d] = ws;
    n = 0;
    while (!req_ready[d] && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready[d]) begin
      fail_now($sformatf("accept_timeout dut%0d addr=%h", d, a));
      req_valid[d] = 1'b0;
      return;
    end
    e.rdata = er;
    e.err = ee;
    e.acc = cyc + 1;
    last_acc[d] = cyc + 1;
    if (d == 0) q0.push_back(e);
    else q1.push_back(e);
    @(negedge clk);
    req_valid[d] = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((q0.size() != 0 || q1.size() != 0 || !req_ready[0] ||
            !req_ready[1]) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) fail_now("drain_timeout");
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      req_valid[d] = 1'b0;
      req_store[d] = 1'b0;
      req_addr[d]  = 12'h0;
      req_wdata[d] = 32'h0;
      req_wstrb[d] = 4'h0;
      rsp_ready[d] = 1'b1;
      seen[d]      = 1'b0;
      last_acc[d]  = 0;
    end
    hs = 0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_req_ready0", 32'(req_ready[0]), 32'd0);
    chk("rst_req_ready1", 32'(req_ready[1]), 32'd0);
    chk("rst_rsp_valid0", 32'(rsp_valid[0]), 32'd0);
    chk("rst_rsp_rdata0", rsp_rdata[0], 32'd0);
    chk("rst_rsp_err0", 32'(rsp_err[0]), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_rst_ready0", 32'(req_ready[0]), 32'd1);
    chk("post_rst_ready1", 32'(req_ready[1]), 32'd1);
    @(negedge clk);

    drive(0, 1'b1, 12'h010, 32'hDEADBEEF, 4'hF, 32'h0, 1'b0);
    drive(0, 1'b0, 12'h010, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0);

    drive(0, 1'b1, 12'h020, 32'h11223344, 4'hF, 32'h0, 1'b0);
    drive(0, 1'b1, 12'h020, 32'hAABBCCDD, 4'h5, 32'h0, 1'b0);
    drive(0, 1'b0, 12'h020, 32'h0, 4'h0, 32'h11BB33DD, 1'b0);
    drive(0, 1'b1, 12'h020, 32'hFFFFFFFF, 4'h0, 32'h0, 1'b0);
    drive(0, 1'b0, 12'h020, 32'h0, 4'h0, 32'h11BB33DD, 1'b0);

    wait_drain();
    rsp_ready[0] = 1'b0;
    drive(0, 1'b0, 12'h010, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0);
    fork
      drive(0, 1'b0, 12'h020, 32'h0, 4'h0, 32'h11BB33DD, 1'b0);
      begin
        int n;
        n = 0;
        while (!rsp_valid[0] && n < 20) begin
          @(negedge clk);
          n++;
        end
        if (!rsp_valid[0]) fail_now("bp_rsp_timeout");
        repeat (5) begin
          #1;
          chk("bp_rsp_valid", 32'(rsp_valid[0]), 32'd1);
          chk("bp_req_ready", 32'(req_ready[0]), 32'd0);
          @(negedge clk);
        end
        rsp_ready[0] = 1'b1;
        hs = cyc + 1;
      end
    join
    chk("bp_accept_edge", last_acc[0], hs + 1);

    drive(1, 1'b1, 12'h005, 32'h0BADCAFE, 4'hF, 32'h0, 1'b0);
    drive(1, 1'b1, 12'h006, 32'h600DF00D, 4'hF, 32'h0, 1'b0);
    drive(1, 1'b0, 12'h005, 32'h0, 4'h0, 32'h0BADCAFE, 1'b0);
    drive(1, 1'b0, 12'h006, 32'h0, 4'h0, 32'h600DF00D, 1'b0);

    drive(0, 1'b1, 12'h030, 32'hCAFEF00D, 4'hF, 32'h0, 1'b0);
    wait_drain();
    drive(0, 1'b1, 12'h030, 32'h12345678, 4'hF, 32'h0, 1'b0);
    rst = 1'b1;
    #1;
    q0.delete();
    chk("midrst_req_ready", 32'(req_ready[0]), 32'd0);
    chk("midrst_rsp_valid", 32'(rsp_valid[0]), 32'd0);
    chk("midrst_rsp_rdata", rsp_rdata[0], 32'd0);
    chk("midrst_rsp_err", 32'(rsp_err[0]), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midrst_release_ready", 32'(req_ready[0]), 32'd1);
    @(negedge clk);
    drive(0, 1'b0, 12'h030, 32'h0, 4'h0, 32'hCAFEF00D, 1'b0);

    drive(0, 1'b1, 12'h000, 32'h55AA55AA, 4'hF, 32'h0, 1'b0);
    drive(0, 1'b1, 12'h400, 32'hFFFFFFFF, 4'hF, 32'h0, EE);
    drive(0, 1'b0, 12'h400, 32'h0, 4'h0, 32'h0, EE);
    drive(0, 1'b0, 12'h000, 32'h0, 4'h0, 32'h55AA55AA, 1'b0);

    wait_drain();
    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
